cla_serial_word_adder: RTL and testbench

- Sequential wide adder that drives the team's 4-bit carry-lookahead slice logic once per clock. It adds WIDTH-bit operands 4 bits at a time and chains the carry across cycles.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Lets the existing 4-bit CLA datapath serve arbitrary word widths at low area.

---
 rtl/cla_serial_word_adder.sv | 167 ++++++++++++++++
 tb/tb_cla_serial_word_adder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cla_serial_word_adder.sv
// cla_serial_word_adder
// Adds two WIDTH-bit operands through a single 4-bit carry-lookahead slice.
// One 4-bit slice is processed per clock, and the carry is carried between
// cycles. Operands are accepted with an in_valid/in_ready handshake. The
// result is held until out_valid/out_ready completes.

module cla_serial_word_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             carry_reg, carry_next;
    logic             cout_reg, cout_next;
    logic [IDXW-1:0]  idx_reg, idx_next;

    logic             accept;
    logic             last_slice;
    logic [3:0]       a_slice, b_slice;
    logic [3:0]       g, p, s;
    logic [4:0]       c;

    assign last_slice = (idx_reg == LAST_IDX);

    // Select the operand nibbles addressed by the current slice index.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_reg == IDXW'(i)) begin
                a_slice = a_reg[4*i +: 4];
                b_slice = b_reg[4*i +: 4];
            end
        end
    end

    // Per-bit generate and propagate terms.
    for (genvar gi = 0; gi < 4; gi++) begin : g_gp
        assign g[gi] = a_slice[gi] & b_slice[gi];
        assign p[gi] = a_slice[gi] ^ b_slice[gi];
        assign s[gi] = p[gi] ^ c[gi];
    end

    // The carries are fully expanded as lookahead terms. They are not rippled.
    assign c[0] = carry_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    // Each sum nibble clears on accept. It loads when its slice is active
    // in RUN, and otherwise it holds its value.
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_sum
        assign sum_next[4*gi +: 4] =
            accept ? 4'b0000 :
            ((state_reg == RUN) && (idx_reg == IDXW'(gi))) ? s :
            sum_reg[4*gi +: 4];
    end

    // Next-state logic, datapath register updates and handshake outputs.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        idx_next   = idx_reg;
        accept     = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    a_next     = a;
                    b_next     = b;
                    carry_next = cin;
                    idx_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy       = 1'b1;
                carry_next = c[4];
                idx_next   = idx_reg + IDXW'(1);
                if (last_slice) begin
                    cout_next  = c[4];
                    idx_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand, carry, index and result registers. Reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            idx_reg   <= idx_next;
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_cla_serial_word_adder.sv
// Testbench for cla_serial_word_adder.
// It instantiates a 16-bit DUT and a 4-bit DUT. Expected results are pushed
// to a queue on accept and popped when the result handshake completes.

module tb_cla_serial_word_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance signals
    logic        iv16, ir16, cin16, ov16, or16, cout16, busy16;
    logic [15:0] a16, b16, sum16;
    // 4-bit instance signals
    logic        iv4, ir4, cin4, ov4, or4, cout4, busy4;
    logic [3:0]  a4, b4, sum4;

    cla_serial_word_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(cin16),
        .out_valid(ov16), .out_ready(or16),
        .sum(sum16), .cout(cout16), .busy(busy16)
    );

    cla_serial_word_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4),
        .sum(sum4), .cout(cout4), .busy(busy4)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_acc = 0;
    logic [16:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] obs_res(input bit w4);
        return w4 ? {12'd0, cout4, sum4} : {cout16, sum16};
    endfunction

    function automatic logic obs_ov(input bit w4);
        return w4 ? ov4 : ov16;
    endfunction

    function automatic logic obs_ir(input bit w4);
        return w4 ? ir4 : ir16;
    endfunction

    function automatic logic obs_busy(input bit w4);
        return w4 ? busy4 : busy16;
    endfunction

    task automatic drive(input bit w4, input logic v, input logic [15:0] av,
                         input logic [15:0] bv, input logic cv);
        if (w4) begin
            iv4 = v; a4 = av[3:0]; b4 = bv[3:0]; cin4 = cv;
        end else begin
            iv16 = v; a16 = av; b16 = bv; cin16 = cv;
        end
    endtask

    task automatic set_or(input bit w4, input logic v);
        if (w4) or4 = v;
        else    or16 = v;
    endtask

    // The caller must be at a negedge with the DUT in IDLE. The task ends at
    // the negedge after the result handshake.
    task automatic run_op(input bit w4, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input int stall, input int exp_lat,
                          input string tag);
        logic [16:0] exp;
        logic [16:0] got;
        int lat;
        check({tag, "/in_ready_idle"}, 17'(obs_ir(w4)), 17'd1);
        drive(w4, 1'b1, av, bv, cv);
        @(posedge clk);
        if (w4) exp = {12'd0, {1'b0, av[3:0]} + {1'b0, bv[3:0]} + 5'(cv)};
        else    exp = {1'b0, av} + {1'b0, bv} + 17'(cv);
        exp_q.push_back(exp);
        @(negedge clk);
        acc_cyc = cyc;
        // Operand changes after the accept must not disturb the result.
        drive(w4, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1);
        check({tag, "/busy_run"}, 17'(obs_busy(w4)), 17'd1);
        check({tag, "/in_ready_run"}, 17'(obs_ir(w4)), 17'd0);
        lat = 0;
        while (obs_ov(w4) !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "/latency"}, 17'(lat), 17'(exp_lat));
        for (int k = 0; k < stall; k++) begin
            drive(w4, (k % 2) == 0, 16'(16'h1357 + k), 16'(16'h2468 + k), 1'(k));
            @(posedge clk);
            @(negedge clk);
            check({tag, "/held"}, obs_res(w4), exp);
            check({tag, "/in_ready_stall"}, 17'(obs_ir(w4)), 17'd0);
            check({tag, "/valid_stall"}, 17'(obs_ov(w4)), 17'd1);
        end
        drive(w4, 1'b0, 16'h0000, 16'h0000, 1'b0);
        set_or(w4, 1'b1);
        got = obs_res(w4);
        @(posedge clk);
        @(negedge clk);
        set_or(w4, 1'b0);
        if (exp_q.size() > 0) check({tag, "/result"}, got, exp_q.pop_front());
        else check({tag, "/queue_empty"}, 17'(exp_q.size()), 17'd1);
        check({tag, "/valid_after_hs"}, 17'(obs_ov(w4)), 17'd0);
        check({tag, "/in_ready_after_hs"}, 17'(obs_ir(w4)), 17'd1);
        check({tag, "/idle_hold"}, obs_res(w4), exp);
    endtask

    initial begin
        iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; or16 = 0;
        iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; or4 = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset/in_ready", 17'(ir16), 17'd1);
        check("reset/out_valid", 17'(ov16), 17'd0);
        check("reset/result", {cout16, sum16}, 17'd0);
        check("reset/busy", 17'(busy16), 17'd0);
        check("reset4/result", {12'd0, cout4, sum4}, 17'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b0, 16'h0006, 16'h000C, 1'b0, 0, 4, "basic16");
        run_op(1'b0, 16'hFFFF, 16'h000B, 1'b1, 0, 4, "chain16a");
        run_op(1'b0, 16'hFFFF, 16'h0000, 1'b1, 0, 4, "chain16b");
        run_op(1'b0, 16'h1234, 16'h4321, 1'b0, 5, 4, "stall16");

        run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 0, 4, "b2b16a");
        first_acc = acc_cyc;
        run_op(1'b0, 16'h8000, 16'h8000, 1'b0, 0, 4, "b2b16b");
        check("b2b16/period", 17'(acc_cyc - first_acc), 17'd6);

        // Reset asserted during RUN after two slices have been processed.
        drive(1'b0, 1'b1, 16'h1111, 16'h1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("midrst/partial_sum", {1'b0, sum16}, 17'h00022);
        rst_n = 1'b0;
        #1;
        check("midrst/out_valid", 17'(ov16), 17'd0);
        check("midrst/result", {cout16, sum16}, 17'd0);
        check("midrst/busy", 17'(busy16), 17'd0);
        check("midrst/in_ready", 17'(ir16), 17'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 0, 4, "post_rst16");

        run_op(1'b1, 16'h0006, 16'h000C, 1'b0, 0, 1, "w4a");
        run_op(1'b1, 16'h000F, 16'h000B, 1'b1, 2, 1, "w4b");

        check("scoreboard/drained", 17'(exp_q.size()), 17'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
